// File: rtl/multicycle_maindec.sv
// ============================================================================
// Module : multicycle_maindec
// Main-decoder FSM sequencing a multicycle MIPS datapath, with a memory
// handshake, optional wait-state timeout and a sticky fault state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multicycle_maindec #(
   parameter int OP_W        = 6,
   parameter int OPER_W      = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5,
   parameter int JAL_EN      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   opcode,
   input  logic              alu_zero,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic              iord,
   output logic              ir_write,
   output logic              pc_en,
   output logic [1:0]        pc_src,
   output logic              reg_we,
   output logic [1:0]        rf_wa_sel,
   output logic [1:0]        rf_wd_sel,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [OPER_W-1:0] operation,
   output logic              instr_done,
   output logic              illegal,
   output logic              mem_fault
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMRD    = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWR    = 4'd5;
   localparam logic [3:0] RTYPE_EX = 4'd6;
   localparam logic [3:0] RTYPE_WB = 4'd7;
   localparam logic [3:0] ADDI_EX  = 4'd8;
   localparam logic [3:0] ADDI_WB  = 4'd9;
   localparam logic [3:0] BEQ_EX   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;
   localparam logic [3:0] JAL      = 4'd12;
   localparam logic [3:0] FAULT    = 4'd13;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);

   localparam logic [OPER_W-1:0] ALU_ADD   = OPER_W'(3'b000);
   localparam logic [OPER_W-1:0] ALU_SUB   = OPER_W'(3'b001);
   localparam logic [OPER_W-1:0] ALU_FUNCT = OPER_W'(3'b010);

   localparam bit               TO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [3:0]       state;
   logic [3:0]       state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             is_mem;
   logic             timeout;

   assign is_mem  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   // A same-cycle ack always beats the timeout.
   assign timeout = TO_EN && is_mem && !mem_ack && (wait_cnt == TO_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         illegal   <= 1'b0;
         mem_fault <= 1'b0;
      end else begin
         state <= state_next;
         if (is_mem && !mem_ack && (state_next == state))
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
         if (state == DECODE && state_next == FAULT)
            illegal <= 1'b1;
         if (timeout)
            mem_fault <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (mem_ack)      state_next = DECODE;
            else if (timeout) state_next = FAULT;
         end
         DECODE: begin
            case (opcode)
               OP_RTYPE:      state_next = RTYPE_EX;
               OP_BEQ:        state_next = BEQ_EX;
               OP_ADDI:       state_next = ADDI_EX;
               OP_LW, OP_SW:  state_next = MEMADR;
               OP_J:          state_next = JUMP;
               OP_JAL:        state_next = (JAL_EN != 0) ? JAL : FAULT;
               default:       state_next = FAULT;
            endcase
         end
         MEMADR:   state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD: begin
            if (mem_ack)      state_next = MEMWB;
            else if (timeout) state_next = FAULT;
         end
         MEMWR: begin
            if (mem_ack)      state_next = FETCH;
            else if (timeout) state_next = FAULT;
         end
         RTYPE_EX: state_next = RTYPE_WB;
         ADDI_EX:  state_next = ADDI_WB;
         MEMWB, RTYPE_WB, ADDI_WB, BEQ_EX, JUMP, JAL:
                   state_next = FETCH;
         FAULT:    state_next = FAULT;
         default:  state_next = FAULT;
      endcase
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      pc_src     = 2'b00;
      reg_we     = 1'b0;
      rf_wa_sel  = 2'b00;
      rf_wd_sel  = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      operation  = ALU_ADD;
      instr_done = 1'b0;
      case (state)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            // Reset holds FETCH, so its gated strobes must also see rst.
            ir_write  = mem_ack && !rst;
            pc_en     = mem_ack && !rst;
         end
         DECODE:   alu_src_b = 2'b11;
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         MEMWB: begin
            reg_we     = 1'b1;
            rf_wd_sel  = 2'b01;
            instr_done = 1'b1;
         end
         MEMWR: begin
            mem_req    = 1'b1;
            mem_we     = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ack;
         end
         RTYPE_EX: begin
            alu_src_a = 1'b1;
            operation = ALU_FUNCT;
         end
         RTYPE_WB: begin
            reg_we     = 1'b1;
            rf_wa_sel  = 2'b01;
            instr_done = 1'b1;
         end
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDI_WB: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
         end
         BEQ_EX: begin
            alu_src_a  = 1'b1;
            operation  = ALU_SUB;
            pc_src     = 2'b01;
            pc_en      = alu_zero;
            instr_done = 1'b1;
         end
         JUMP: begin
            pc_en      = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
         end
         JAL: begin
            pc_en      = 1'b1;
            pc_src     = 2'b10;
            reg_we     = 1'b1;
            rf_wa_sel  = 2'b10;
            rf_wd_sel  = 2'b10;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_maindec.sv
// ============================================================================
// Module : tb_multicycle_maindec
// Directed bench: default instance (a) and a JAL-disabled, 4-cycle-timeout
// instance (b) share stimulus; outputs are compared as packed vectors.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_maindec;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ack = 1'b0;

   logic       a_req, a_we, a_iord, a_irw, a_pce, a_rwe, a_sa, a_done, a_ill, a_mf;
   logic [1:0] a_pcs, a_wa, a_wd, a_sb;
   logic [2:0] a_op;
   logic       b_req, b_we, b_iord, b_irw, b_pce, b_rwe, b_sa, b_done, b_ill, b_mf;
   logic [1:0] b_pcs, b_wa, b_wd, b_sb;
   logic [2:0] b_op;

   always #5 clk = ~clk;

   multicycle_maindec dut_a (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ack(mem_ack),
      .mem_req(a_req), .mem_we(a_we), .iord(a_iord), .ir_write(a_irw), .pc_en(a_pce),
      .pc_src(a_pcs), .reg_we(a_rwe), .rf_wa_sel(a_wa), .rf_wd_sel(a_wd),
      .alu_src_a(a_sa), .alu_src_b(a_sb), .operation(a_op), .instr_done(a_done),
      .illegal(a_ill), .mem_fault(a_mf)
   );

   multicycle_maindec #(.MEM_TIMEOUT(4), .CNT_W(3), .JAL_EN(0)) dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ack(mem_ack),
      .mem_req(b_req), .mem_we(b_we), .iord(b_iord), .ir_write(b_irw), .pc_en(b_pce),
      .pc_src(b_pcs), .reg_we(b_rwe), .rf_wa_sel(b_wa), .rf_wd_sel(b_wd),
      .alu_src_a(b_sa), .alu_src_b(b_sb), .operation(b_op), .instr_done(b_done),
      .illegal(b_ill), .mem_fault(b_mf)
   );

   logic [31:0] a_vec, b_vec;
   assign a_vec = {11'd0, a_req, a_we, a_iord, a_irw, a_pce, a_pcs, a_rwe, a_wa, a_wd,
                   a_sa, a_sb, a_op, a_done, a_ill, a_mf};
   assign b_vec = {11'd0, b_req, b_we, b_iord, b_irw, b_pce, b_pcs, b_rwe, b_wa, b_wd,
                   b_sa, b_sb, b_op, b_done, b_ill, b_mf};

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] v(
      input logic req, we, io, irw, pce, input logic [1:0] pcs, input logic rwe,
      input logic [1:0] wa, wd, input logic sa, input logic [1:0] sb,
      input logic [2:0] op, input logic done, ill, mf);
      return {11'd0, req, we, io, irw, pce, pcs, rwe, wa, wd, sa, sb, op, done, ill, mf};
   endfunction

   logic [31:0] E_FA, E_FW, E_DEC, E_REX, E_RWB, E_MADR, E_MRD, E_MWB, E_MWR_W, E_MWR_A;
   logic [31:0] E_AWB, E_BEQ1, E_BEQ0, E_J, E_JAL, E_FLT_I, E_FLT_M;

   // Inputs change on negedge; outputs sampled 1 time unit later.
   task automatic cyc(input string tag, input logic [31:0] ea, input logic [31:0] eb);
      #1;
      check({tag, "/a"}, a_vec, ea);
      check({tag, "/b"}, b_vec, eb);
      @(negedge clk);
   endtask

   initial begin
      E_FA    = v(1,0,0,1,1,2'b00,0,2'b00,2'b00,0,2'b01,3'b000,0,0,0);
      E_FW    = v(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b01,3'b000,0,0,0);
      E_DEC   = v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b11,3'b000,0,0,0);
      E_REX   = v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,3'b010,0,0,0);
      E_RWB   = v(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,2'b00,3'b000,1,0,0);
      E_MADR  = v(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b10,3'b000,0,0,0);
      E_MRD   = v(1,0,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,0,0);
      E_MWB   = v(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,2'b00,3'b000,1,0,0);
      E_MWR_W = v(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,0,0);
      E_MWR_A = v(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,1,0,0);
      E_AWB   = v(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,2'b00,3'b000,1,0,0);
      E_BEQ1  = v(0,0,0,0,1,2'b01,0,2'b00,2'b00,1,2'b00,3'b001,1,0,0);
      E_BEQ0  = v(0,0,0,0,0,2'b01,0,2'b00,2'b00,1,2'b00,3'b001,1,0,0);
      E_J     = v(0,0,0,0,1,2'b10,0,2'b00,2'b00,0,2'b00,3'b000,1,0,0);
      E_JAL   = v(0,0,0,0,1,2'b10,1,2'b10,2'b10,0,2'b00,3'b000,1,0,0);
      E_FLT_I = v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,1,0);
      E_FLT_M = v(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,3'b000,0,0,1);

      // Reset with ack high: FETCH Moore outputs only, no strobes.
      mem_ack = 1'b1;
      @(negedge clk);
      cyc("reset", E_FW, E_FW);
      rst = 1'b0;

      opcode = 6'b000000;
      cyc("r_fetch", E_FA, E_FA);
      cyc("r_dec", E_DEC, E_DEC);
      cyc("r_ex", E_REX, E_REX);
      cyc("r_wb", E_RWB, E_RWB);

      // LW with three wait states; on b the ack lands exactly at the timeout edge.
      opcode = 6'b100011;
      cyc("lw_fetch", E_FA, E_FA);
      cyc("lw_dec", E_DEC, E_DEC);
      cyc("lw_adr", E_MADR, E_MADR);
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MRD, E_MRD);
      mem_ack = 1'b1;
      cyc("lw_rd_ack", E_MRD, E_MRD);
      cyc("lw_wb", E_MWB, E_MWB);

      opcode = 6'b000100;
      alu_zero = 1'b1;
      cyc("beq1_fetch", E_FA, E_FA);
      cyc("beq1_dec", E_DEC, E_DEC);
      cyc("beq1_ex", E_BEQ1, E_BEQ1);
      alu_zero = 1'b0;
      cyc("beq0_fetch", E_FA, E_FA);
      cyc("beq0_dec", E_DEC, E_DEC);
      cyc("beq0_ex", E_BEQ0, E_BEQ0);

      // JAL: a executes it, b treats it as illegal and stays in FAULT.
      opcode = 6'b000011;
      cyc("jal_fetch", E_FA, E_FA);
      cyc("jal_dec", E_DEC, E_DEC);
      cyc("jal_ex", E_JAL, E_FLT_I);

      // SW on a, reset asserted mid-MEMWR.
      opcode = 6'b101011;
      cyc("sw_fetch", E_FA, E_FLT_I);
      cyc("sw_dec", E_DEC, E_FLT_I);
      cyc("sw_adr", E_MADR, E_FLT_I);
      mem_ack = 1'b0;
      #1;
      check("sw_wr_wait/a", a_vec, E_MWR_W);
      check("sw_wr_wait/b", b_vec, E_FLT_I);
      #1 rst = 1'b1;
      #1;
      check("mid_rst/a", a_vec, E_FW);
      check("mid_rst/b", b_vec, E_FW);
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b1;

      opcode = 6'b001000;
      cyc("addi_fetch", E_FA, E_FA);
      cyc("addi_dec", E_DEC, E_DEC);
      cyc("addi_ex", E_MADR, E_MADR);
      cyc("addi_wb", E_AWB, E_AWB);

      opcode = 6'b000010;
      cyc("j_fetch", E_FA, E_FA);
      cyc("j_dec", E_DEC, E_DEC);
      cyc("j_ex", E_J, E_J);

      opcode = 6'b101011;
      cyc("sw2_fetch", E_FA, E_FA);
      cyc("sw2_dec", E_DEC, E_DEC);
      cyc("sw2_adr", E_MADR, E_MADR);
      cyc("sw2_wr", E_MWR_A, E_MWR_A);

      // Timeout in FETCH: b faults after 4 waits, a keeps waiting.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) cyc("to_wait", E_FW, E_FW);
      cyc("to_fault", E_FW, E_FLT_M);
      mem_ack = 1'b1;
      cyc("to_stay", E_FA, E_FLT_M);

      // Ack in the 4th wait cycle wins over the timeout.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) cyc("to2_wait", E_FW, E_FW);
      mem_ack = 1'b1;
      opcode = 6'b000000;
      cyc("to2_ack", E_FA, E_FA);
      cyc("to2_dec", E_DEC, E_DEC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
